// File: rtl/pack_host_pkg.sv
// Shared constants and types for the Pack host proxy: message geometry,
// default method IDs and the bit layout of the request and indication messages.
package pack_host_pkg;

   localparam int HDR_WIDTH     = 16;
   localparam int PAYLOAD_WIDTH = 128;
   localparam int MSG_WIDTH     = HDR_WIDTH + PAYLOAD_WIDTH;
   localparam int CNT_WIDTH     = 8;

   localparam logic [HDR_WIDTH-1:0] SAY_ID   = 16'd0;
   localparam logic [HDR_WIDTH-1:0] HEARD_ID = 16'd0;

   localparam int HDR_MSB = 143;
   localparam int HDR_LSB = 128;

   // request (say) layout; bits below SAY_SEQ_LSB are zero
   localparam int SAY_V_MSB   = 127;
   localparam int SAY_V_LSB   = 96;
   localparam int SAY_SEQ_MSB = 95;
   localparam int SAY_SEQ_LSB = 88;

   // indication (heard) layout; bits below IND_SEQ_LSB are ignored
   localparam int IND_V_MSB   = 127;
   localparam int IND_V_LSB   = 96;
   localparam int IND_WC_MSB  = 95;
   localparam int IND_WC_LSB  = 88;
   localparam int IND_RC_MSB  = 87;
   localparam int IND_RC_LSB  = 80;
   localparam int IND_SEQ_MSB = 79;
   localparam int IND_SEQ_LSB = 72;

   typedef struct packed {
      logic [31:0] v;
      logic [7:0]  write_count;
      logic [7:0]  read_count;
      logic [7:0]  seqno;
   } heard_t;

endpackage

// File: rtl/pack_host_proxy_stage.sv
// One-entry registered ENA/RDY slice; sustains one transfer per cycle when
// the consumer is ready and holds its entry stable while stalled.
module pack_host_stage #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_ena_i,
   input  logic [W-1:0] in_data_i,
   output logic         in_rdy_o,
   output logic         out_ena_o,
   output logic [W-1:0] out_data_o,
   input  logic         out_rdy_i
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;
   logic         in_fire, out_fire;

   assign in_rdy_o   = !full_q || out_rdy_i;
   assign in_fire    = in_ena_i && in_rdy_o;
   assign out_fire   = full_q && out_rdy_i;
   assign out_ena_o  = full_q;
   assign out_data_o = data_q;

   // a load in the same cycle as a drain keeps the stage full
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (in_fire) begin
         full_d = 1'b1;
         data_d = in_data_i;
      end else if (out_fire) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/pack_host_proxy.sv
// Host-side Pack proxy: packs say calls into request messages and unpacks
// indication messages into heard calls. Optional PACK_HOST_SEQCHK_EN adds seqErrCount.
module pack_host_proxy #(
   parameter int                    HDR_WIDTH     = pack_host_pkg::HDR_WIDTH,
   parameter int                    PAYLOAD_WIDTH = pack_host_pkg::PAYLOAD_WIDTH,
   parameter logic [HDR_WIDTH-1:0]  SAY_ID        = pack_host_pkg::SAY_ID,
   parameter logic [HDR_WIDTH-1:0]  HEARD_ID      = pack_host_pkg::HEARD_ID,
   parameter int                    CNT_WIDTH     = pack_host_pkg::CNT_WIDTH
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               say__ENA,
   input  logic [31:0]                        say_v,
   input  logic [7:0]                         say_seqno,
   output logic                               say__RDY,
   output logic                               req_enq__ENA,
   output logic [HDR_WIDTH+PAYLOAD_WIDTH-1:0] req_enq_v,
   input  logic                               req_enq__RDY,
   input  logic                               ind_enq__ENA,
   input  logic [HDR_WIDTH+PAYLOAD_WIDTH-1:0] ind_enq_v,
   output logic                               ind_enq__RDY,
   output logic                               heard__ENA,
   output logic [31:0]                        heard_v,
   output logic [7:0]                         heard_writeCount,
   output logic [7:0]                         heard_readCount,
   output logic [7:0]                         heard_seqno,
   input  logic                               heard__RDY,
   output logic [CNT_WIDTH-1:0]               dropCount
`ifdef PACK_HOST_SEQCHK_EN
   ,
   output logic [CNT_WIDTH-1:0]               seqErrCount
`endif
);

   import pack_host_pkg::*;

   localparam int MSG_W = HDR_WIDTH + PAYLOAD_WIDTH;

   logic [MSG_W-1:0]     req_msg;
   heard_t               ind_fields, heard_q;
   logic                 hdr_hit, ind_fire;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
   logic                 unused_ind_bits;

   always_comb begin
      req_msg                          = '0;
      req_msg[HDR_MSB:HDR_LSB]         = SAY_ID;
      req_msg[SAY_V_MSB:SAY_V_LSB]     = say_v;
      req_msg[SAY_SEQ_MSB:SAY_SEQ_LSB] = say_seqno;
   end

   pack_host_stage #(.W(MSG_W)) u_req_stage (
      .clk_i      (CLK),
      .rst_i      (RST),
      .in_ena_i   (say__ENA),
      .in_data_i  (req_msg),
      .in_rdy_o   (say__RDY),
      .out_ena_o  (req_enq__ENA),
      .out_data_o (req_enq_v),
      .out_rdy_i  (req_enq__RDY)
   );

   assign ind_fields.v           = ind_enq_v[IND_V_MSB:IND_V_LSB];
   assign ind_fields.write_count = ind_enq_v[IND_WC_MSB:IND_WC_LSB];
   assign ind_fields.read_count  = ind_enq_v[IND_RC_MSB:IND_RC_LSB];
   assign ind_fields.seqno       = ind_enq_v[IND_SEQ_MSB:IND_SEQ_LSB];
   assign unused_ind_bits        = ^ind_enq_v[IND_SEQ_LSB-1:0];

   assign hdr_hit  = (ind_enq_v[HDR_MSB:HDR_LSB] == HEARD_ID);
   assign ind_fire = ind_enq__ENA && ind_enq__RDY;

   // unknown IDs are still accepted (RDY unaffected) but never loaded
   pack_host_stage #(.W($bits(heard_t))) u_ind_stage (
      .clk_i      (CLK),
      .rst_i      (RST),
      .in_ena_i   (ind_enq__ENA && hdr_hit),
      .in_data_i  (ind_fields),
      .in_rdy_o   (ind_enq__RDY),
      .out_ena_o  (heard__ENA),
      .out_data_o (heard_q),
      .out_rdy_i  (heard__RDY)
   );

   assign heard_v          = heard_q.v;
   assign heard_writeCount = heard_q.write_count;
   assign heard_readCount  = heard_q.read_count;
   assign heard_seqno      = heard_q.seqno;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (ind_fire && !hdr_hit && (drop_cnt_q != '1))
         drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) drop_cnt_q <= '0;
      else     drop_cnt_q <= drop_cnt_d;
   end

   assign dropCount = drop_cnt_q;

`ifdef PACK_HOST_SEQCHK_EN
   logic [7:0]           exp_seq_q, exp_seq_d;
   logic [CNT_WIDTH-1:0] seq_err_q, seq_err_d;

   always_comb begin
      exp_seq_d = exp_seq_q;
      seq_err_d = seq_err_q;
      if (heard__ENA && heard__RDY) begin
         exp_seq_d = heard_seqno + 8'd1;
         if ((heard_seqno != exp_seq_q) && (seq_err_q != '1))
            seq_err_d = seq_err_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         exp_seq_q <= '0;
         seq_err_q <= '0;
      end else begin
         exp_seq_q <= exp_seq_d;
         seq_err_q <= seq_err_d;
      end
   end

   assign seqErrCount = seq_err_q;
`endif

endmodule
